fetch_unit: RTL and testbench

- Instruction fetch front end that feeds the instruction decoder.
- Keeps the fetch PC and issues word reads to instruction memory over a request/grant/rvalid interface.
- Buffers returned words in a small in-order FIFO and presents instr/op/funct/PC to the decode stage with a valid/ready handshake.
- Takes redirects (branch taken, J/JAL/JR targets) from the datapath, flushes wrong-path instructions, and restarts fetch at the target.

---
 rtl/fetch_unit.sv | 160 ++++++++++++++++
 tb/tb_fetch_unit.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front end for the decode stage. It holds the fetch PC,
// issues word reads to instruction memory over a req/gnt/rvalid interface,
// buffers returned words in order and hands them to decode with valid/ready.
// A redirect flushes wrong-path work and restarts fetch at the new target.
//
// Ports
//   clk_i, rst_ni      clock (rising edge), asynchronous active-low reset
//   imem_req_o         fetch request valid (held until granted)
//   imem_addr_o        fetch word address, bits [1:0] always zero
//   imem_gnt_i         memory accepted the request this cycle
//   imem_rvalid_i      read data valid, responses return in request order
//   imem_rdata_i       read data
//   instr_valid_o      instruction available to decode
//   instr_ready_i      decode accepts the instruction
//   instr_o            instruction word (0 while the buffer is empty)
//   op_o, funct_o      instr_o[31:26], instr_o[5:0]
//   pc_o, pc_plus4_o   address of instr_o and that address + 4 (link value)
//   redirect_i         flush and restart fetch (highest priority)
//   redirect_pc_i      restart address, bits [1:0] ignored
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [5:0]  op_o,
  output logic [5:0]  funct_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] ptr_t;

  localparam ptr_t        PTR_LAST = ptr_t'(DEPTH - 1);
  localparam logic [CW:0] DEPTH_C  = (CW + 1)'(DEPTH);

  // Circular pointer increment for a DEPTH that need not be a power of two.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == PTR_LAST) ? '0 : p + ptr_t'(1);
  endfunction

  logic        started;      // keeps imem_req_o low until the first cycle out of reset
  logic [31:0] fetch_pc;
  cnt_t        outstanding;  // granted requests whose response has not returned
  cnt_t        outstanding_nxt;
  cnt_t        discard;      // oldest outstanding responses that belong to a flushed path
  cnt_t        count;        // buffered instructions
  ptr_t        rd_ptr, wr_ptr;
  ptr_t        pcq_rd, pcq_wr;

  logic [31:0] buf_instr [DEPTH];
  logic [31:0] buf_pc    [DEPTH];
  logic [31:0] pcq       [DEPTH];  // address of each outstanding request, in issue order

  logic        grant, drop, push, pop;
  logic [CW:0] credit_used;
  logic        unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc_i[1:0];

  // Credit check uses registered state only, so ready and gnt never reach req.
  assign credit_used = {1'b0, outstanding} + {1'b0, count};
  assign imem_req_o  = started && (credit_used < DEPTH_C);
  assign imem_addr_o = fetch_pc;

  assign grant = imem_req_o && imem_gnt_i;
  assign drop  = imem_rvalid_i && (redirect_i || (discard != '0));
  assign push  = imem_rvalid_i && !drop;
  assign pop   = instr_valid_o && instr_ready_i && !redirect_i;

  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
    outstanding_nxt = outstanding;
    case ({grant, imem_rvalid_i})
      2'b10:   outstanding_nxt = outstanding + cnt_t'(1);
      2'b01:   outstanding_nxt = outstanding - cnt_t'(1);
      default: outstanding_nxt = outstanding;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      started     <= 1'b0;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      pcq_rd      <= '0;
      pcq_wr      <= '0;
    end else begin
      started     <= 1'b1;
      outstanding <= outstanding_nxt;
      // The PC queue tracks every request, flushed or not, so it is never cleared.
      if (grant)         pcq_wr <= ptr_inc(pcq_wr);
      if (imem_rvalid_i) pcq_rd <= ptr_inc(pcq_rd);

      if (redirect_i) begin
        fetch_pc <= {redirect_pc_i[31:2], 2'b00};
        // Everything still in flight after this edge is wrong-path, including
        // a request granted now; a response arriving now is already dropped.
        discard  <= outstanding_nxt;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (grant) fetch_pc <= fetch_pc + 32'd4;
        if (imem_rvalid_i && (discard != '0)) discard <= discard - cnt_t'(1);
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        case ({push, pop})
          2'b10:   count <= count + cnt_t'(1);
          2'b01:   count <= count - cnt_t'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: storage arrays are not reset; the counters and pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (grant) pcq[pcq_wr] <= fetch_pc;
    if (push) begin
      buf_instr[wr_ptr] <= imem_rdata_i;
      buf_pc[wr_ptr]    <= pcq[pcq_rd];
    end
  end

  assign instr_valid_o = (count != '0);
  assign instr_o       = instr_valid_o ? buf_instr[rd_ptr] : 32'd0;
  assign op_o          = instr_o[31:26];
  assign funct_o       = instr_o[5:0];
  assign pc_o          = instr_valid_o ? buf_pc[rd_ptr] : 32'd0;
  assign pc_plus4_o    = instr_valid_o ? (buf_pc[rd_ptr] + 32'd4) : 32'd0;

  // A response with nothing outstanding means the memory broke the protocol.
  rvalid_has_outstanding: assert property (
    @(posedge clk_i) disable iff (!rst_ni) imem_rvalid_i |-> (outstanding != '0)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. A behavioural memory model answers
// requests in order with a configurable latency and grant probability. The
// reference model tracks in-flight requests (with a "wrong path" flag), the
// decode-side queue and the expected program-order PC stream; the DUT outputs
// are compared against it on every cycle.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int unsigned DEPTH    = 3;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [5:0]  op_o;
  logic [5:0]  funct_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .op_o          (op_o),
    .funct_o       (funct_o),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
    bit          stale;
  } flight_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  flight_t     mem_q[$];    // granted, not yet returned (oldest first)
  entry_t      m_buf[$];    // instructions waiting for decode
  logic [31:0] pop_log[$];  // PCs handed to decode, in order
  logic [31:0] m_fpc;       // next address to fetch
  logic [31:0] exp_pc;      // next PC of the program-order stream
  bit          m_started;
  int          edge_n;
  int          gnt_pct, lat_min, lat_max;
  int          checks, errors;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: account for the edge just taken, compare, then drive memory.
  task automatic step();
    bit          g, rv, rd, redir;
    logic [31:0] tgt;
    flight_t     head;
    entry_t      e;
    bit          exp_req;
    @(negedge clk);
    if (rst_n) begin
      g     = imem_gnt_i;
      rv    = imem_rvalid_i;
      rd    = instr_ready_i;
      redir = redirect_i;
      tgt   = redirect_pc_i;
      edge_n++;
      head  = '{32'h0, 32'h0, 0, 1'b1};
      if (rv) head = mem_q.pop_front();
      if (redir) foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      if (g) mem_q.push_back('{m_fpc, mem_word(m_fpc),
                                edge_n + $urandom_range(lat_max, lat_min), redir});
      if (redir) begin
        m_fpc = {tgt[31:2], 2'b00};
        exp_pc = {tgt[31:2], 2'b00};
        m_buf.delete();
      end else begin
        if (g) m_fpc = m_fpc + 32'd4;
        if (rd && m_buf.size() > 0) begin
          e = m_buf.pop_front();
          pop_log.push_back(e.pc);
          exp_pc = e.pc + 32'd4;
        end
        if (rv && !head.stale) m_buf.push_back('{head.addr, head.data});
      end
      m_started = 1'b1;
    end
    redirect_i = 1'b0;

    exp_req = m_started && (mem_q.size() + m_buf.size() < DEPTH);
    check32("req", 32'(imem_req_o), 32'(exp_req));
    if (exp_req) check32("addr", imem_addr_o, m_fpc);
    check32("valid", 32'(instr_valid_o), 32'(m_buf.size() > 0));
    if (m_buf.size() > 0) begin
      check32("instr", instr_o, m_buf[0].instr);
      check32("op", 32'(op_o), 32'(m_buf[0].instr[31:26]));
      check32("funct", 32'(funct_o), 32'(m_buf[0].instr[5:0]));
      check32("pc", pc_o, m_buf[0].pc);
      check32("pc_plus4", pc_plus4_o, m_buf[0].pc + 32'd4);
      if (instr_valid_o) check32("stream_pc", pc_o, exp_pc);
    end else begin
      check32("instr_empty", instr_o, 32'h0);
      check32("pc_empty", pc_o, 32'h0);
      check32("pc_plus4_empty", pc_plus4_o, 32'h0);
    end

    imem_gnt_i    = rst_n && imem_req_o && ($urandom_range(99, 0) < gnt_pct);
    imem_rvalid_i = rst_n && (mem_q.size() > 0) && (mem_q[0].due <= edge_n + 1);
    imem_rdata_i  = imem_rvalid_i ? mem_q[0].data : $urandom();
  endtask

  // Asynchronous reset taken mid-cycle; called at a negedge (or time 0).
  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1;
    check32("rst_valid_now", 32'(instr_valid_o), 32'h0);
    check32("rst_req_now", 32'(imem_req_o), 32'h0);
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0;
    redirect_i = 1'b0;
    mem_q.delete();
    m_buf.delete();
    pop_log.delete();
    m_fpc = RESET_PC;
    exp_pc = RESET_PC;
    m_started = 1'b0;
    edge_n = 0;
    repeat (2) @(negedge clk);
    check32("rst_instr", instr_o, 32'h0);
    check32("rst_pc_plus4", pc_plus4_o, 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int g_first, v_first, n, t, seen;
    logic [31:0] ga[$];

    checks = 0; errors = 0;
    rst_n = 1'b0; instr_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    gnt_pct = 100; lat_min = 1; lat_max = 1;

    // Zero-wait memory, decode always ready.
    apply_reset();
    instr_ready_i = 1'b1;
    g_first = -1; v_first = -1; n = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (instr_valid_o && v_first < 0) begin
        v_first = i;
        check32("first_op", 32'(op_o), 32'h08);
        check32("first_pc", pc_o, 32'h0);
        check32("first_pc_plus4", pc_plus4_o, 32'h4);
      end
      if (imem_gnt_i) begin
        if (g_first < 0) g_first = i;
        ga.push_back(imem_addr_o);
      end
      if (i >= 10 && instr_valid_o) n++;
    end
    check32("first_grant_cycle", 32'(g_first), 32'd0);
    check32("first_valid_cycle", 32'(v_first), 32'(g_first + 2));
    check32("grant_addr0", ga[0], 32'h0);
    check32("grant_addr1", ga[1], 32'h4);
    check32("grant_addr2", ga[2], 32'h8);
    check32("grant_every_cycle", 32'(ga.size()), 32'd30);
    check32("sustained_valid", 32'(n), 32'd20);

    // Decode stalled: credit limits fetch to DEPTH, nothing is lost.
    apply_reset();
    instr_ready_i = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (imem_gnt_i) n++;
    end
    check32("stall_grants", 32'(n), 32'(DEPTH));
    check32("stall_req_low", 32'(imem_req_o), 32'h0);
    check32("stall_pc_frozen", pc_o, 32'h0);
    instr_ready_i = 1'b1;
    t = 0;
    while (pop_log.size() < 4 && t < 20) begin step(); t++; end
    check32("release_done", 32'(pop_log.size() >= 4), 32'h1);
    if (pop_log.size() >= 4) begin
      check32("release_pc0", pop_log[0], 32'h0);
      check32("release_pc1", pop_log[1], 32'h4);
      check32("release_pc2", pop_log[2], 32'h8);
      check32("release_pc3", pop_log[3], 32'hC);
    end

    // Slow memory: redirect with two fetches in flight.
    apply_reset();
    lat_min = 3; lat_max = 3; instr_ready_i = 1'b1;
    t = 0;
    while (mem_q.size() != 2 && t < 20) begin step(); t++; end
    check32("two_outstanding", 32'(mem_q.size()), 32'd2);
    redirect_i = 1'b1; redirect_pc_i = 32'h40;
    pop_log.delete();
    t = 0;
    step();
    while (pop_log.size() == 0 && t < 40) begin step(); t++; end
    check32("slow_redirect_seen", 32'(pop_log.size() > 0), 32'h1);
    if (pop_log.size() > 0) check32("slow_redirect_pc", pop_log[0], 32'h40);

    // Redirect coinciding with grant of 0x8 and rvalid of 0x4.
    apply_reset();
    lat_min = 1; lat_max = 1; instr_ready_i = 1'b1;
    t = 0;
    while (!(imem_gnt_i && imem_addr_o == 32'h8 && imem_rvalid_i && mem_q[0].addr == 32'h4)
           && t < 20) begin
      step(); t++;
    end
    check32("coincide_found", 32'(t < 20), 32'h1);
    redirect_i = 1'b1; redirect_pc_i = 32'h40;
    pop_log.delete();
    step();
    check32("coincide_next_addr", imem_addr_o, 32'h40);
    t = 0;
    while (pop_log.size() < 3 && t < 20) begin step(); t++; end
    n = 0;
    foreach (pop_log[i]) if (pop_log[i] == 32'h4 || pop_log[i] == 32'h8) n++;
    check32("coincide_no_stale", 32'(n), 32'h0);
    if (pop_log.size() > 0) check32("coincide_first_pc", pop_log[0], 32'h40);

    // Redirect with unaligned target near the top: address wraps to 0.
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
    step();
    check32("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
    ga.delete(); seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (imem_gnt_i) ga.push_back(imem_addr_o);
      step();
      if (instr_valid_o && pc_o == 32'hFFFF_FFFC) begin
        seen = 1;
        check32("wrap_pc_plus4", pc_plus4_o, 32'h0);
      end
    end
    check32("wrap_instr_seen", 32'(seen), 32'h1);
    if (ga.size() >= 2) begin
      check32("wrap_grant0", ga[0], 32'hFFFF_FFFC);
      check32("wrap_grant1", ga[1], 32'h0);
    end else check32("wrap_grants", 32'(ga.size()), 32'd2);

    // Reset in the middle of traffic.
    apply_reset();
    lat_min = 3; lat_max = 3; instr_ready_i = 1'b0;
    t = 0;
    while (!(mem_q.size() >= 1 && m_buf.size() >= 1) && t < 30) begin step(); t++; end
    check32("midop_busy", 32'(instr_valid_o), 32'h1);
    apply_reset();
    lat_min = 1; lat_max = 1;
    step();
    check32("restart_req", 32'(imem_req_o), 32'h1);
    check32("restart_addr", imem_addr_o, RESET_PC);

    // Randomised traffic: grant probability, latency, stalls and redirects.
    instr_ready_i = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) begin
        gnt_pct = $urandom_range(100, 30);
        lat_min = $urandom_range(2, 1);
        lat_max = lat_min + $urandom_range(2, 0);
      end
      step();
      instr_ready_i = ($urandom_range(99, 0) < 70);
      if ($urandom_range(99, 0) < 4) begin
        redirect_i = 1'b1;
        redirect_pc_i = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                                    : ($urandom() & 32'h0000_0FFF);
      end
    end
    lat_min = 1; lat_max = 1; gnt_pct = 100; instr_ready_i = 1'b1;
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
